// File: rtl/ysyx_23060124_mem_pkg.sv
// Shared types for the IFU/LSU SRAM arbiter.
// FSM states, owner encodings and bus width defaults.
package ysyx_23060124_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SREQ,
    S_SRSP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } owner_t;

endpackage

// File: rtl/ysyx_23060124_rr_arb2.sv
// Two-input round-robin arbiter, bit 0 = IFU, bit 1 = LSU.
// last_grant starts at LSU so the IFU wins the first conflict.
module ysyx_23060124_rr_arb2
  import ysyx_23060124_mem_pkg::*;
(
  input  logic       clk,
  input  logic       ifu_rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_lsu;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = last_lsu ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge ifu_rst) begin
    if (!ifu_rst) begin
      last_lsu <= 1'b1;
    end else if (grant_en && (gnt != 2'b00)) begin
      last_lsu <= gnt[1];
    end
  end

endmodule

// File: rtl/ysyx_23060124_mem_arbiter.sv
// Shares the single SRAM port between IFU and LSU.
// One transaction in flight; response routed back to its owner.
module ysyx_23060124_mem_arbiter
  import ysyx_23060124_mem_pkg::*;
#(
  parameter int ADDR_W = ysyx_23060124_mem_pkg::ADDR_W,
  parameter int DATA_W = ysyx_23060124_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              ifu_rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rsp_rdata,
  output logic              ifu_rsp_err,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rsp_rdata,
  output logic              lsu_rsp_err,

  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_req_wen,
  output logic [DATA_W-1:0] s_req_wdata,
  output logic [DATA_W/8-1:0] s_req_wmask,
  input  logic              s_rsp_valid,
  output logic              s_rsp_ready,
  input  logic [DATA_W-1:0] s_rsp_rdata,
  input  logic              s_rsp_err
);

  state_t              state;
  owner_t              owner;
  logic [ADDR_W-1:0]   h_addr;
  logic                h_wen;
  logic [DATA_W-1:0]   h_wdata;
  logic [DATA_W/8-1:0] h_wmask;

  logic [1:0] gnt;
  logic       idle;
  logic       accept;
  logic       ifu_own;
  logic       lsu_own;

  // Reset gates the grant so no ready leaks out while held in reset.
  assign idle   = (state == S_IDLE) && ifu_rst;
  assign ifu_req_ready = idle && gnt[0];
  assign lsu_req_ready = idle && gnt[1];
  assign accept = ifu_req_ready || lsu_req_ready;

  ysyx_23060124_rr_arb2 u_arb (
    .clk      (clk),
    .ifu_rst  (ifu_rst),
    .req      ({lsu_req_valid, ifu_req_valid}),
    .grant_en (accept),
    .gnt      (gnt)
  );

  always_ff @(posedge clk or negedge ifu_rst) begin
    if (!ifu_rst) begin
      state   <= S_IDLE;
      owner   <= OWN_NONE;
      h_addr  <= '0;
      h_wen   <= 1'b0;
      h_wdata <= '0;
      h_wmask <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_SREQ;
            if (gnt[0]) begin
              owner   <= OWN_IFU;
              h_addr  <= ifu_req_addr;
              h_wen   <= 1'b0;
              h_wdata <= '0;
              h_wmask <= '0;
            end else begin
              owner   <= OWN_LSU;
              h_addr  <= lsu_req_addr;
              h_wen   <= lsu_req_wen;
              h_wdata <= lsu_req_wdata;
              h_wmask <= lsu_req_wmask;
            end
          end
        end
        S_SREQ: begin
          if (s_req_ready) state <= S_SRSP;
        end
        S_SRSP: begin
          if (s_rsp_valid && s_rsp_ready) begin
            state <= S_IDLE;
            owner <= OWN_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s_req_valid = (state == S_SREQ);
  assign s_req_addr  = h_addr;
  assign s_req_wen   = h_wen;
  assign s_req_wdata = h_wdata;
  assign s_req_wmask = h_wmask;

  assign ifu_own = (state == S_SRSP) && (owner == OWN_IFU);
  assign lsu_own = (state == S_SRSP) && (owner == OWN_LSU);

  assign s_rsp_ready = (ifu_own && ifu_rsp_ready) ||
                       (lsu_own && lsu_rsp_ready);

  assign ifu_rsp_valid = ifu_own && s_rsp_valid;
  assign ifu_rsp_rdata = ifu_own ? s_rsp_rdata : '0;
  assign ifu_rsp_err   = ifu_own && s_rsp_err;

  // Writes return no data even if the SRAM drives its bus.
  assign lsu_rsp_valid = lsu_own && s_rsp_valid;
  assign lsu_rsp_rdata = (lsu_own && !h_wen) ? s_rsp_rdata : '0;
  assign lsu_rsp_err   = lsu_own && s_rsp_err;

endmodule

// File: tb/tb_ysyx_23060124_mem_arbiter.sv
// Directed, table-driven bench for the IFU/LSU SRAM arbiter.
// One table row = inputs for one cycle plus outputs expected in it.
module tb_ysyx_23060124_mem_arbiter;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A4 = 32'h8000_0004;
  localparam logic [31:0] A8 = 32'h8000_0008;
  localparam logic [31:0] AC = 32'h8000_000C;
  localparam logic [31:0] LA = 32'h8000_0200;
  localparam logic [31:0] WA = 32'h8000_0100;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] iv, ia, lv, lw, la, ld, lm;
    logic [31:0] sqr, spv, spd, spe, irr, lrr;
    logic [31:0] e_irdy, e_lrdy, e_sv, e_sa, e_sw, e_sd, e_sm;
    logic [31:0] e_sr, e_iv, e_id, e_ie, e_lv, e_ld;
  } vec_t;

  logic        clk;
  logic        ifu_rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  logic        s_req_valid, s_req_ready;
  logic [31:0] s_req_addr;
  logic        s_req_wen;
  logic [31:0] s_req_wdata;
  logic [3:0]  s_req_wmask;
  logic        s_rsp_valid, s_rsp_ready;
  logic [31:0] s_rsp_rdata;
  logic        s_rsp_err;

  int checks = 0;
  int errors = 0;
  vec_t tv[64];
  int   nv = 0;

  ysyx_23060124_mem_arbiter dut (
    .clk           (clk),
    .ifu_rst       (ifu_rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .s_req_valid   (s_req_valid),
    .s_req_ready   (s_req_ready),
    .s_req_addr    (s_req_addr),
    .s_req_wen     (s_req_wen),
    .s_req_wdata   (s_req_wdata),
    .s_req_wmask   (s_req_wmask),
    .s_rsp_valid   (s_rsp_valid),
    .s_rsp_ready   (s_rsp_ready),
    .s_rsp_rdata   (s_rsp_rdata),
    .s_rsp_err     (s_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input vec_t v);
    tv[nv] = v;
    nv++;
  endtask

  task automatic apply(input vec_t v);
    ifu_req_valid = v.iv[0];
    ifu_req_addr  = v.ia;
    lsu_req_valid = v.lv[0];
    lsu_req_wen   = v.lw[0];
    lsu_req_addr  = v.la;
    lsu_req_wdata = v.ld;
    lsu_req_wmask = v.lm[3:0];
    s_req_ready   = v.sqr[0];
    s_rsp_valid   = v.spv[0];
    s_rsp_rdata   = v.spd;
    s_rsp_err     = v.spe[0];
    ifu_rsp_ready = v.irr[0];
    lsu_rsp_ready = v.lrr[0];
  endtask

  task automatic compare(input vec_t v, input int r);
    chk("ifu_req_ready", r, {31'b0, ifu_req_ready}, v.e_irdy);
    chk("lsu_req_ready", r, {31'b0, lsu_req_ready}, v.e_lrdy);
    chk("s_req_valid", r, {31'b0, s_req_valid}, v.e_sv);
    if (v.e_sv[0]) begin
      chk("s_req_addr", r, s_req_addr, v.e_sa);
      chk("s_req_wen", r, {31'b0, s_req_wen}, v.e_sw);
      chk("s_req_wdata", r, s_req_wdata, v.e_sd);
      chk("s_req_wmask", r, {28'b0, s_req_wmask}, v.e_sm);
    end
    chk("s_rsp_ready", r, {31'b0, s_rsp_ready}, v.e_sr);
    chk("ifu_rsp_valid", r, {31'b0, ifu_rsp_valid}, v.e_iv);
    chk("ifu_rsp_rdata", r, ifu_rsp_rdata, v.e_id);
    chk("ifu_rsp_err", r, {31'b0, ifu_rsp_err}, v.e_ie);
    chk("lsu_rsp_valid", r, {31'b0, lsu_rsp_valid}, v.e_lv);
    chk("lsu_rsp_rdata", r, lsu_rsp_rdata, v.e_ld);
  endtask

  initial begin
    // Both masters valid: IFU, LSU, IFU, LSU
    add('{1,A4,1,0,LA,0,15,1,0,0,0,1,1, 1,0,0,0,0,0,0,0,0,0,0,0,0});
    add('{1,A4,1,0,LA,0,15,1,0,0,0,1,1, 0,0,1,A4,0,0,0,0,0,0,0,0,0});
    add('{1,A4,1,0,LA,0,15,1,1,'h1111,0,1,1, 0,0,0,0,0,0,0,1,1,'h1111,0,0,0});
    add('{1,A8,1,0,LA,0,15,1,0,0,0,1,1, 0,1,0,0,0,0,0,0,0,0,0,0,0});
    add('{1,A8,1,0,LA,0,15,1,0,0,0,1,1, 0,0,1,LA,0,0,15,0,0,0,0,0,0});
    add('{1,A8,1,0,LA,0,15,1,1,'h2222,0,1,1, 0,0,0,0,0,0,0,1,0,0,0,1,'h2222});
    add('{1,A8,1,0,LA,0,15,1,0,0,0,1,1, 1,0,0,0,0,0,0,0,0,0,0,0,0});
    add('{1,A8,1,0,LA,0,15,1,0,0,0,1,1, 0,0,1,A8,0,0,0,0,0,0,0,0,0});
    add('{1,A8,1,0,LA,0,15,1,1,'h3333,0,1,1, 0,0,0,0,0,0,0,1,1,'h3333,0,0,0});
    add('{1,AC,1,0,LA,0,15,1,0,0,0,1,1, 0,1,0,0,0,0,0,0,0,0,0,0,0});
    add('{1,AC,1,0,LA,0,15,1,0,0,0,1,1, 0,0,1,LA,0,0,15,0,0,0,0,0,0});
    add('{1,AC,1,0,LA,0,15,1,1,'h4444,0,1,1, 0,0,0,0,0,0,0,1,0,0,0,1,'h4444});
    // Single IFU read, early s_rsp_valid in SREQ must be ignored
    add('{1,A0,0,0,0,0,0,1,0,0,0,1,1, 1,0,0,0,0,0,0,0,0,0,0,0,0});
    add('{0,0,0,0,0,0,0,1,1,'hFFFF,0,1,1, 0,0,1,A0,0,0,0,0,0,0,0,0,0});
    add('{0,0,0,0,0,0,0,1,1,'h413,0,1,1, 0,0,0,0,0,0,0,1,1,'h413,0,0,0});
    // Error pass-through
    add('{1,AC,0,0,0,0,0,1,0,0,0,1,1, 1,0,0,0,0,0,0,0,0,0,0,0,0});
    add('{0,0,0,0,0,0,0,1,0,0,0,1,1, 0,0,1,AC,0,0,0,0,0,0,0,0,0});
    add('{0,0,0,0,0,0,0,1,1,'hBAD,1,1,1, 0,0,0,0,0,0,0,1,1,'hBAD,1,0,0});
    // LSU write with request and response backpressure
    add('{0,0,1,1,WA,WD,15,0,0,0,0,1,1, 0,1,0,0,0,0,0,0,0,0,0,0,0});
    for (int i = 0; i < 4; i++)
      add('{1,A0,1,0,'h1234,0,3,0,0,0,0,1,1, 0,0,1,WA,1,WD,15,0,0,0,0,0,0});
    add('{1,A0,1,0,'h1234,0,3,1,0,0,0,1,1, 0,0,1,WA,1,WD,15,0,0,0,0,0,0});
    for (int i = 0; i < 3; i++)
      add('{1,A0,1,0,'h1234,0,3,0,1,'h5555,0,1,0, 0,0,0,0,0,0,0,0,0,0,0,1,0});
    add('{1,A0,1,0,'h1234,0,3,0,1,'h5555,0,1,1, 0,0,0,0,0,0,0,1,0,0,0,1,0});
    add('{0,0,0,0,0,0,0,0,0,0,0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0});

    // Reset state with busy-looking inputs
    ifu_rst = 1'b0;
    apply('{1,A0,1,0,LA,0,15,1,1,'h99,1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0});
    #2;
    chk("rst ifu_req_ready", -1, {31'b0, ifu_req_ready}, 0);
    chk("rst lsu_req_ready", -1, {31'b0, lsu_req_ready}, 0);
    chk("rst s_req_valid", -1, {31'b0, s_req_valid}, 0);
    chk("rst s_req_addr", -1, s_req_addr, 0);
    chk("rst s_rsp_ready", -1, {31'b0, s_rsp_ready}, 0);
    chk("rst ifu_rsp_valid", -1, {31'b0, ifu_rsp_valid}, 0);
    chk("rst ifu_rsp_rdata", -1, ifu_rsp_rdata, 0);
    tick();
    tick();
    ifu_rst = 1'b1;

    for (int i = 0; i < nv; i++) begin
      apply(tv[i]);
      #1;
      compare(tv[i], i);
      tick();
    end

    // Reset while waiting in SRSP
    apply('{1,A0,0,0,0,0,0,1,0,0,0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0});
    #1;
    chk("seq ifu_req_ready", 100, {31'b0, ifu_req_ready}, 1);
    tick();
    ifu_req_valid = 1'b0;
    #1;
    chk("seq s_req_valid", 101, {31'b0, s_req_valid}, 1);
    tick();
    #1;
    chk("seq s_rsp_ready", 102, {31'b0, s_rsp_ready}, 1);
    ifu_rst = 1'b0;
    s_rsp_valid = 1'b1;
    s_rsp_rdata = 32'h77;
    #1;
    chk("mid-rst s_rsp_ready", 103, {31'b0, s_rsp_ready}, 0);
    chk("mid-rst ifu_rsp_valid", 103, {31'b0, ifu_rsp_valid}, 0);
    chk("mid-rst ifu_rsp_rdata", 103, ifu_rsp_rdata, 0);
    chk("mid-rst lsu_rsp_valid", 103, {31'b0, lsu_rsp_valid}, 0);
    chk("mid-rst s_req_valid", 103, {31'b0, s_req_valid}, 0);
    chk("mid-rst s_req_addr", 103, s_req_addr, 0);
    tick();
    s_rsp_valid = 1'b0;
    ifu_rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1;
    lsu_req_addr = LA;
    #1;
    chk("post-rst ifu_req_ready", 104, {31'b0, ifu_req_ready}, 1);
    chk("post-rst lsu_req_ready", 104, {31'b0, lsu_req_ready}, 0);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    #1;
    chk("post-rst s_req_valid", 105, {31'b0, s_req_valid}, 1);
    chk("post-rst s_req_addr", 105, s_req_addr, 32'h8000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
